// File: rtl/bounce_pkg.sv
// Shared types and the per-square start-up table for bounce_multi.
// Square colours are RGB565; the background colour sits behind all squares.
package bounce_pkg;

    localparam int SQ_W = 10;
    localparam int CW_R = 5;
    localparam int CW_G = 6;
    localparam int CW_B = 5;

    typedef struct packed {
        logic [SQ_W-1:0] x;
        logic [SQ_W-1:0] y;
        logic [SQ_W-1:0] size;
        logic [SQ_W-1:0] speed;
        logic [CW_R-1:0] r;
        logic [CW_G-1:0] g;
        logic [CW_B-1:0] b;
    } sq_cfg_t;

    typedef enum logic {
        ST_IDLE,
        ST_UPDATE
    } upd_state_t;

    localparam logic [CW_R-1:0] BG_R = 5'd2;
    localparam logic [CW_G-1:0] BG_G = 6'd12;
    localparam logic [CW_B-1:0] BG_B = 5'd14;

    // Columns: x, y, size, speed, r, g, b
    localparam sq_cfg_t SQ_INIT [8] = '{
        '{10'd0,   10'd0,   10'd60, 10'd9,  5'd31, 6'd0,  5'd0 },
        '{10'd80,  10'd70,  10'd40, 10'd5,  5'd0,  6'd63, 5'd0 },
        '{10'd300, 10'd150, 10'd30, 10'd7,  5'd0,  6'd0,  5'd31},
        '{10'd200, 10'd200, 10'd50, 10'd3,  5'd31, 6'd63, 5'd0 },
        '{10'd20,  10'd180, 10'd20, 10'd11, 5'd0,  6'd63, 5'd31},
        '{10'd400, 10'd20,  10'd24, 10'd2,  5'd31, 6'd0,  5'd31},
        '{10'd350, 10'd220, 10'd16, 10'd13, 5'd16, 6'd32, 5'd16},
        '{10'd120, 10'd120, 10'd36, 10'd4,  5'd31, 6'd63, 5'd31}
    };

endpackage

// File: rtl/bounce_axis_step.sv
// One-axis position step for a bouncing square: moves by speed and clamps
// against the far edge (res) or zero, reversing direction on a clamp.
module bounce_axis_step #(
    parameter int CORDW = 10
) (
    input  logic [CORDW-1:0] pos_i,
    input  logic             dir_i,
    input  logic [CORDW-1:0] size_i,
    input  logic [CORDW-1:0] speed_i,
    input  logic [CORDW-1:0] res_i,
    output logic [CORDW-1:0] pos_next_o,
    output logic             dir_next_o,
    output logic             clamp_o
);
    localparam logic [CORDW:0] ONE = 1;

    logic [CORDW:0] pos_w;
    logic [CORDW:0] size_w;
    logic [CORDW:0] speed_w;
    logic [CORDW:0] res_w;
    logic [CORDW:0] far_edge;

    // One extra bit of headroom so pos + size + speed never wraps.
    assign pos_w    = {1'b0, pos_i};
    assign size_w   = {1'b0, size_i};
    assign speed_w  = {1'b0, speed_i};
    assign res_w    = {1'b0, res_i};
    assign far_edge = pos_w + size_w + speed_w;

    always_comb begin
        pos_next_o = pos_i;
        dir_next_o = dir_i;
        clamp_o    = 1'b0;
        if (!dir_i) begin
            if (far_edge >= res_w - ONE) begin
                pos_next_o = CORDW'(res_w - size_w - ONE);
                dir_next_o = 1'b1;
                clamp_o    = 1'b1;
            end else begin
                pos_next_o = CORDW'(pos_w + speed_w);
            end
        end else begin
            if (pos_w < speed_w) begin
                pos_next_o = '0;
                dir_next_o = 1'b0;
                clamp_o    = 1'b1;
            end else begin
                pos_next_o = CORDW'(pos_w - speed_w);
            end
        end
    end

endmodule

// File: rtl/bounce_multi.sv
// N_SQ bouncing squares, stepped one per clock after each frame tick and painted
// by fixed priority (square 0 on top). Define BOUNCE_FLASH_EN for clamp flashing.
module bounce_multi
    import bounce_pkg::*;
#(
    parameter int CORDW     = 10,
    parameter int H_RES     = 480,
    parameter int V_RES     = 272,
    parameter int N_SQ      = 4,
    parameter int FRAME_NUM = 1
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             de,
    input  logic             frame,
    input  logic             run,
    output logic [CW_R-1:0]  r,
    output logic [CW_G-1:0]  g,
    output logic [CW_B-1:0]  b,
    output logic             bounce,
    output logic             busy
);
    localparam int CNTW = $clog2(FRAME_NUM) + 1;
    localparam int IDXW = (N_SQ > 1) ? $clog2(N_SQ) : 1;

    upd_state_t      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [CNTW-1:0] cnt_frame_q;
    logic            tick;
    logic            updating;
    logic            bounce_q;

    logic [CORDW-1:0] x_all     [N_SQ];
    logic [CORDW-1:0] y_all     [N_SQ];
    logic [CORDW-1:0] size_all  [N_SQ];
    logic [CORDW-1:0] speed_all [N_SQ];
    logic [N_SQ-1:0]  dx_all;
    logic [N_SQ-1:0]  dy_all;
    logic [N_SQ-1:0]  hit;
    logic [CW_R-1:0]  paint_r   [N_SQ];
    logic [CW_G-1:0]  paint_g   [N_SQ];
    logic [CW_B-1:0]  paint_b   [N_SQ];

    logic [CORDW-1:0] cur_x, cur_y, cur_size, cur_speed;
    logic [CORDW-1:0] nx, ny;
    logic             cur_dx, cur_dy, ndx, ndy;
    logic             clamp_x, clamp_y, clamp_any;

    logic [CW_R-1:0] r_q, r_d;
    logic [CW_G-1:0] g_q, g_d;
    logic [CW_B-1:0] b_q, b_d;

    // Tick is judged on the count before this frame's increment.
    assign tick     = frame && (cnt_frame_q == '0);
    assign updating = (state_q == ST_UPDATE);

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            cnt_frame_q <= '0;
        end else if (frame) begin
            cnt_frame_q <= (cnt_frame_q == CNTW'(FRAME_NUM - 1)) ? '0 : cnt_frame_q + 1'b1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (tick && run) begin
                    state_d = ST_UPDATE;
                    idx_d   = '0;
                end
            end
            ST_UPDATE: begin
                if (idx_q == IDXW'(N_SQ - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Shared step datapath: the square under idx is muxed in and written back.
    assign cur_x     = x_all[idx_q];
    assign cur_y     = y_all[idx_q];
    assign cur_size  = size_all[idx_q];
    assign cur_speed = speed_all[idx_q];
    assign cur_dx    = dx_all[idx_q];
    assign cur_dy    = dy_all[idx_q];

    bounce_axis_step #(.CORDW(CORDW)) u_step_x (
        .pos_i      (cur_x),
        .dir_i      (cur_dx),
        .size_i     (cur_size),
        .speed_i    (cur_speed),
        .res_i      (CORDW'(H_RES)),
        .pos_next_o (nx),
        .dir_next_o (ndx),
        .clamp_o    (clamp_x)
    );

    bounce_axis_step #(.CORDW(CORDW)) u_step_y (
        .pos_i      (cur_y),
        .dir_i      (cur_dy),
        .size_i     (cur_size),
        .speed_i    (cur_speed),
        .res_i      (CORDW'(V_RES)),
        .pos_next_o (ny),
        .dir_next_o (ndy),
        .clamp_o    (clamp_y)
    );

    assign clamp_any = clamp_x | clamp_y;

    genvar gi;
    for (gi = 0; gi < N_SQ; gi++) begin : g_sq
        logic [CORDW-1:0] x_q, y_q;
        logic             dx_q, dy_q;
        logic             wr;
        logic [CORDW:0]   x_end, y_end;

        assign wr = updating && (idx_q == IDXW'(gi));

        always_ff @(posedge clk_pix) begin
            if (rst_pix) begin
                x_q  <= CORDW'(SQ_INIT[gi].x);
                y_q  <= CORDW'(SQ_INIT[gi].y);
                dx_q <= 1'b0;
                dy_q <= 1'b0;
            end else if (wr) begin
                x_q  <= nx;
                y_q  <= ny;
                dx_q <= ndx;
                dy_q <= ndy;
            end
        end

        assign x_all[gi]     = x_q;
        assign y_all[gi]     = y_q;
        assign dx_all[gi]    = dx_q;
        assign dy_all[gi]    = dy_q;
        assign size_all[gi]  = CORDW'(SQ_INIT[gi].size);
        assign speed_all[gi] = CORDW'(SQ_INIT[gi].speed);

        assign x_end   = {1'b0, x_q} + {1'b0, size_all[gi]};
        assign y_end   = {1'b0, y_q} + {1'b0, size_all[gi]};
        assign hit[gi] = (sx >= x_q) && ({1'b0, sx} < x_end) &&
                         (sy >= y_q) && ({1'b0, sy} < y_end);

`ifdef BOUNCE_FLASH_EN
        logic [1:0] flash_q;

        // A fresh clamp reloads the counter even if a tick lands in the same cycle.
        always_ff @(posedge clk_pix) begin
            if (rst_pix) begin
                flash_q <= 2'd0;
            end else if (wr && clamp_any) begin
                flash_q <= 2'd3;
            end else if (tick && (flash_q != 2'd0)) begin
                flash_q <= flash_q - 2'd1;
            end
        end

        assign paint_r[gi] = (flash_q != 2'd0) ? ~SQ_INIT[gi].r : SQ_INIT[gi].r;
        assign paint_g[gi] = (flash_q != 2'd0) ? ~SQ_INIT[gi].g : SQ_INIT[gi].g;
        assign paint_b[gi] = (flash_q != 2'd0) ? ~SQ_INIT[gi].b : SQ_INIT[gi].b;
`else
        assign paint_r[gi] = SQ_INIT[gi].r;
        assign paint_g[gi] = SQ_INIT[gi].g;
        assign paint_b[gi] = SQ_INIT[gi].b;
`endif
    end

    // Walk from the highest index down so the lowest-index hit is applied last.
    always_comb begin
        r_d = BG_R;
        g_d = BG_G;
        b_d = BG_B;
        for (int i = N_SQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                r_d = paint_r[i];
                g_d = paint_g[i];
                b_d = paint_b[i];
            end
        end
        if (!de) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            bounce_q <= 1'b0;
        end else begin
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            bounce_q <= updating && clamp_any;
        end
    end

    assign r      = r_q;
    assign g      = g_q;
    assign b      = b_q;
    assign bounce = bounce_q;
    assign busy   = updating;

endmodule
